// File: rtl/axis_pkt_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
//   Shared types and helpers for the AXI-Stream packet arbiter.
//   - arb_state_t : arbiter FSM state (IDLE / PASS / GAP), also exported on
//                   the top-level debug port.
//   - rr_pick()   : round-robin picker. It searches from last_ptr+1 upwards,
//                   wrapping modulo n, and returns a one-hot vector of the
//                   first requester found. The result is 0 when nobody
//                   requests.
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  // Upper bound on port count the picker helper handles; ports are passed
  // zero-extended to this width.
  localparam int MAX_PORTS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic logic [MAX_PORTS-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input int unsigned          last_ptr,
    input int unsigned          n
  );
    logic [MAX_PORTS-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
      if (i <= n) begin
        idx = (last_ptr + i) % n;
        if (!found && req[idx[4:0]]) begin
          pick[idx[4:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_arbiter_if
//   Bundles the NUM_PORTS input streams and the single output stream of the
//   packet arbiter.
//   Input streams are packed; port k data is axis_i_tdata[k*W +: W] with
//   W = AXIS_BYTES*8.
//
//   Handshake: a beat moves on a rising clk edge when tvalid and tready are
//   both high in that cycle. tready may depend combinationally on tvalid.
//   tdata/tlast are only meaningful while tvalid is high.
//
//   modport slave  : the arbiter's view. It consumes the inputs, drives the
//                    input readies, and drives the output stream.
//   modport master : the environment's view. It drives the sources and the
//                    sink ready.
// -----------------------------------------------------------------------------
interface axis_pkt_arbiter_if #(
  parameter int AXIS_BYTES = 1,
  parameter int NUM_PORTS  = 2
);
  logic [NUM_PORTS-1:0]              axis_i_tready;
  logic [NUM_PORTS-1:0]              axis_i_tvalid;
  logic [NUM_PORTS-1:0]              axis_i_tlast;
  logic [NUM_PORTS*AXIS_BYTES*8-1:0] axis_i_tdata;
  logic                              axis_o_tready;
  logic                              axis_o_tvalid;
  logic                              axis_o_tlast;
  logic [AXIS_BYTES*8-1:0]           axis_o_tdata;

  modport slave (
    output axis_i_tready,
    input  axis_i_tvalid,
    input  axis_i_tlast,
    input  axis_i_tdata,
    input  axis_o_tready,
    output axis_o_tvalid,
    output axis_o_tlast,
    output axis_o_tdata
  );

  modport master (
    input  axis_i_tready,
    output axis_i_tvalid,
    output axis_i_tlast,
    output axis_i_tdata,
    output axis_o_tready,
    input  axis_o_tvalid,
    input  axis_o_tlast,
    input  axis_o_tdata
  );
endinterface

// File: rtl/axis_pkt_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker.
//   Ports:
//     req      in  NUM_PORTS  request vector (one bit per port)
//     last_ptr in  IDX_W      index of the port served last
//     onehot   out NUM_PORTS  one-hot pick; 0 when no request
//     idx      out IDX_W      binary index of the pick (0 when none)
//     any      out 1          at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_ptr,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic [MAX_PORTS-1:0] req_ext;
  logic [MAX_PORTS-1:0] pick_ext;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    pick_ext = rr_pick(req_ext, {{(32-IDX_W){1'b0}}, last_ptr}, 32'(NUM_PORTS));
  end

  assign onehot = pick_ext[NUM_PORTS-1:0];
  assign any    = |pick_ext;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_pkt_arbiter
//   Shares one AXI-Stream output between NUM_PORTS packet sources, one whole
//   packet at a time. Packets are arbitrated round-robin. A grant is held
//   from the first beat to tlast, so the output is never interleaved. After
//   every packet the output is held silent for a programmable gap (for
//   example, an inter-frame gap ahead of a MAC).
//
//   Ports:
//     clk             in   clock
//     sresetn         in   synchronous active-low reset
//     cfg_gap_cycles  in   GAP_WIDTH bits; gap length, sampled at packet end
//     bus             if   axis_pkt_arbiter_if.slave (inputs + output stream)
//     grant           out  NUM_PORTS one-hot owner of the output; 0 when none
//     busy            out  high while in PASS or GAP
//     dbg_state       out  current FSM state
//
//   Timing: after a tlast handshake, o_tvalid stays low for gap+1 cycles.
//   These are gap GAP cycles plus one IDLE arbitration cycle. Then the next
//   packet may start.
// -----------------------------------------------------------------------------
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int AXIS_BYTES = 1,
  parameter int NUM_PORTS  = 2,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 sresetn,
  input  logic [GAP_WIDTH-1:0] cfg_gap_cycles,
  axis_pkt_arbiter_if.slave    bus,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 busy,
  output arb_state_t           dbg_state
);

  localparam int W     = AXIS_BYTES * 8;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IDX_W-1:0]     gidx_q;   // binary copy of grant_q, drives the mux
  logic [IDX_W-1:0]     ptr_q;    // last-served port
  logic [GAP_WIDTH-1:0] gap_q;
  logic [GAP_WIDTH-1:0] ctr_q;

  logic [NUM_PORTS-1:0] arb_onehot;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  logic                 sel_valid;
  logic                 sel_last;
  logic [W-1:0]         sel_data;
  logic                 pass;
  logic                 pkt_end;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req      (bus.axis_i_tvalid),
    .last_ptr (ptr_q),
    .onehot   (arb_onehot),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  // Select the granted input. This is only used while in PASS.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_valid = bus.axis_i_tvalid[i];
        sel_last  = bus.axis_i_tlast[i];
        sel_data  = bus.axis_i_tdata[i*W +: W];
      end
    end
  end

  assign pass    = (state_q == ST_PASS);
  assign pkt_end = pass && sel_valid && bus.axis_o_tready && sel_last;

  // Passthrough is combinational. Outside PASS everything stays silent.
  assign bus.axis_o_tvalid = pass & sel_valid;
  assign bus.axis_o_tlast  = pass & sel_last;
  assign bus.axis_o_tdata  = pass ? sel_data : '0;
  assign bus.axis_i_tready = pass ? (grant_q & {NUM_PORTS{bus.axis_o_tready}}) : '0;

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(NUM_PORTS - 1);
      gap_q   <= '0;
      ctr_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Requests are re-evaluated every IDLE cycle. A source that drops
          // valid before it is picked loses nothing.
          if (arb_any) begin
            grant_q <= arb_onehot;
            gidx_q  <= arb_idx;
            ptr_q   <= arb_idx;
            state_q <= ST_PASS;
          end
        end
        ST_PASS: begin
          // The grant is held through input bubbles and output stalls. Only
          // the tlast handshake releases it.
          if (pkt_end) begin
            gap_q   <= cfg_gap_cycles;
            grant_q <= '0;
            if (cfg_gap_cycles == '0) begin
              state_q <= ST_IDLE;
            end else begin
              ctr_q   <= GAP_WIDTH'(1);
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // ctr counts 1..gap_q, so it never exceeds the max of the field.
          if (ctr_q == gap_q) state_q <= ST_IDLE;
          else                ctr_q   <= ctr_q + GAP_WIDTH'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
module tb_axis_pkt_arbiter;
  import axis_arb_pkg::*;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int GW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          sresetn = 1'b0;
  logic [GW-1:0] cfg = '0;
  always #5 clk = ~clk;

  axis_pkt_arbiter_if #(.AXIS_BYTES(1), .NUM_PORTS(NP)) bus ();
  logic [NP-1:0] grant_w;
  logic          busy_w;
  arb_state_t    dbg_w;

  axis_pkt_arbiter #(.AXIS_BYTES(1), .NUM_PORTS(NP), .GAP_WIDTH(GW)) dut (
    .clk            (clk),
    .sresetn        (sresetn),
    .cfg_gap_cycles (cfg),
    .bus            (bus),
    .grant          (grant_w),
    .busy           (busy_w),
    .dbg_state      (dbg_w)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  // Source packet queues: {last, data} per beat.
  logic [8:0] src_q [NP][$];
  // Scoreboard of beats expected on the output, in order.
  logic [W:0] exp_q[$];

  // Stimulus knobs.
  int unsigned vpct    = 100;
  int          rdy_mode = 0;   // 0: always ready, 1: toggle 1010, 2: random
  int unsigned rdy_pct = 70;
  bit          cfg_rand = 1'b0;
  int          cyc = 0;

  // Behavioural model: who owns the output, how many silent gap cycles
  // remain, and the port served last.
  int m_owner    = -1;
  int m_gap_left = 0;
  int m_last     = NP - 1;

  // Observations of DUT behaviour, used by the literal checks.
  int            order_code = 0;  // digits: port+1 of each new grant
  int            dead_log[8];
  int            dead_n = 0;
  bit            armed = 1'b0;
  int            since = 0;
  int            hs_count = 0;
  int            pkt_done = 0;
  logic [NP-1:0] prev_grant = '0;
  logic [NP-1:0] obs_grant;
  logic          obs_busy;
  logic          obs_ovalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic load_pkt(input int p, input int len);
    for (int i = 0; i < len; i++)
      src_q[p].push_back({(i == len - 1), 8'($urandom_range(0, 255))});
  endtask

  task automatic clear_logs();
    order_code = 0;
    dead_n     = 0;
    armed      = 1'b0;
    since      = 0;
    hs_count   = 0;
    pkt_done   = 0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model, pass posedge.
  task automatic step();
    logic [NP-1:0]   tv, tl, tv_n, tl_n, e_gr, e_rdy;
    logic [NP*W-1:0] d_n;
    logic [W-1:0]    td [NP];
    logic            e_ov, e_ol, e_busy, ohs;
    logic [W-1:0]    e_od;
    logic [W:0]      eb;
    int              p;
    // drive this cycle's inputs
    tv_n = '0; tl_n = '0; d_n = '0;
    for (int k = 0; k < NP; k++) begin
      if (src_q[k].size() > 0 && $urandom_range(0, 99) < vpct) begin
        tv_n[k]         = 1'b1;
        tl_n[k]         = src_q[k][0][8];
        d_n[k*W +: W]   = src_q[k][0][7:0];
      end
    end
    bus.axis_i_tvalid = tv_n;
    bus.axis_i_tlast  = tl_n;
    bus.axis_i_tdata  = d_n;
    case (rdy_mode)
      1:       bus.axis_o_tready = ((cyc % 2) == 0);
      2:       bus.axis_o_tready = ($urandom_range(0, 99) < rdy_pct);
      default: bus.axis_o_tready = 1'b1;
    endcase
    if (cfg_rand && $urandom_range(0, 9) == 0) cfg = GW'($urandom_range(0, 6));

    @(negedge clk);
    cyc++;
    tv = bus.axis_i_tvalid;
    tl = bus.axis_i_tlast;
    for (int k = 0; k < NP; k++) td[k] = bus.axis_i_tdata[k*W +: W];

    // expected outputs from the model
    e_ov = 1'b0; e_ol = 1'b0; e_od = '0; e_gr = '0; e_rdy = '0;
    e_busy = (m_owner >= 0) || (m_gap_left > 0);
    if (m_owner >= 0) begin
      e_ov = tv[m_owner];
      e_ol = tl[m_owner];
      e_od = td[m_owner];
      e_gr[m_owner] = 1'b1;
      if (bus.axis_o_tready) e_rdy[m_owner] = 1'b1;
    end
    chk("o_tvalid", 32'(bus.axis_o_tvalid), 32'(e_ov));
    chk("grant",    32'(grant_w),           32'(e_gr));
    chk("busy",     32'(busy_w),            32'(e_busy));
    chk("i_tready", 32'(bus.axis_i_tready), 32'(e_rdy));
    if (e_ov) begin
      chk("o_tdata", 32'(bus.axis_o_tdata), 32'(e_od));
      chk("o_tlast", 32'(bus.axis_o_tlast), 32'(e_ol));
    end

    // scoreboard on real output handshakes
    ohs = bus.axis_o_tvalid && bus.axis_o_tready;
    if (ohs) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'({bus.axis_o_tlast, bus.axis_o_tdata}), 32'h1_0000);
      end else begin
        eb = exp_q.pop_front();
        chk("sb_beat", 32'({bus.axis_o_tlast, bus.axis_o_tdata}), 32'(eb));
      end
    end

    // observations
    obs_grant  = grant_w;
    obs_busy   = busy_w;
    obs_ovalid = bus.axis_o_tvalid;
    if (grant_w != '0 && prev_grant == '0) begin
      for (int k = 0; k < NP; k++) if (grant_w[k]) order_code = order_code * 10 + k + 1;
    end
    prev_grant = grant_w;
    if (bus.axis_o_tvalid) begin
      if (armed) begin
        if (dead_n < 8) dead_log[dead_n] = since;
        dead_n++;
        armed = 1'b0;
      end
    end else if (armed) begin
      since++;
    end
    if (ohs) hs_count++;
    if (ohs && bus.axis_o_tlast) begin
      armed = 1'b1;
      since = 0;
      pkt_done++;
    end

    // sources consume on their own handshakes
    for (int k = 0; k < NP; k++)
      if (tv[k] && bus.axis_i_tready[k]) void'(src_q[k].pop_front());

    // advance model across the coming edge
    if (!sresetn) begin
      m_owner = -1; m_gap_left = 0; m_last = NP - 1;
      for (int k = 0; k < NP; k++) src_q[k].delete();
      exp_q.delete();
      armed = 1'b0;
    end else if (m_owner >= 0) begin
      if (e_ov && bus.axis_o_tready && e_ol) begin
        m_gap_left = int'(cfg);
        m_owner    = -1;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (m_owner < 0 && tv[p]) m_owner = p;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        for (int i = 0; i < src_q[m_owner].size(); i++) begin
          exp_q.push_back(src_q[m_owner][i]);
          if (src_q[m_owner][i][8]) break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sresetn = 1'b0;
    step();
    step();
    sresetn = 1'b1;
    clear_logs();
  endtask

  task automatic drain(input string name, input int max_cyc);
    bit done;
    int src_left;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      src_left = 0;
      for (int k = 0; k < NP; k++) src_left += src_q[k].size();
      if (src_left == 0 && exp_q.size() == 0 && m_owner < 0 && m_gap_left == 0) done = 1'b1;
      else step();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // ---------------- tests ----------------
  initial begin
    bus.axis_i_tvalid = '0;
    bus.axis_i_tlast  = '0;
    bus.axis_i_tdata  = '0;
    bus.axis_o_tready = 1'b0;

    // Reset state
    do_reset();
    step();
    chk("reset_grant",  32'(obs_grant),  32'd0);
    chk("reset_busy",   32'(obs_busy),   32'd0);
    chk("reset_ovalid", 32'(obs_ovalid), 32'd0);

    // T1: port0 3-beat packet, gap 4, followed by another -> 5 dead cycles
    do_reset();
    cfg = 8'd4;
    load_pkt(0, 3); load_pkt(0, 2);
    drain("t1_drain", 200);
    chk("t1_order", 32'(order_code), 32'd11);
    chk("t1_dead",  32'(dead_log[0]), 32'd5);

    // T2: ports 0,1 backlogged 2-beat packets, gap 0
    do_reset();
    cfg = 8'd0;
    load_pkt(0, 2); load_pkt(0, 2); load_pkt(1, 2); load_pkt(1, 2);
    drain("t2_drain", 200);
    chk("t2_order", 32'(order_code), 32'd1212);
    chk("t2_dead_n", 32'(dead_n), 32'd3);
    chk("t2_dead0", 32'(dead_log[0]), 32'd1);
    chk("t2_dead2", 32'(dead_log[2]), 32'd1);

    // T3: port1 packet under toggling o_tready, port0 arrives mid-packet
    do_reset();
    cfg = 8'd1;
    rdy_mode = 1;
    load_pkt(1, 5);
    for (int i = 0; i < 50 && hs_count < 1; i++) step();
    load_pkt(0, 2);
    drain("t3_drain", 200);
    chk("t3_order", 32'(order_code), 32'd21);
    rdy_mode = 0;

    // T4: gap 10 latched, changed to 2 during the gap
    do_reset();
    cfg = 8'd10;
    load_pkt(0, 2); load_pkt(0, 2); load_pkt(0, 2);
    for (int i = 0; i < 50 && pkt_done < 1; i++) step();
    step(); step(); step();
    cfg = 8'd2;
    drain("t4_drain", 300);
    chk("t4_dead0", 32'(dead_log[0]), 32'd11);
    chk("t4_dead1", 32'(dead_log[1]), 32'd3);

    // T5: three ports, gap 255, single-beat packets
    do_reset();
    cfg = 8'd255;
    load_pkt(0, 1); load_pkt(1, 1); load_pkt(2, 1); load_pkt(0, 1);
    drain("t5_drain", 2000);
    chk("t5_order", 32'(order_code), 32'd1231);
    chk("t5_dead0", 32'(dead_log[0]), 32'd256);
    chk("t5_dead2", 32'(dead_log[2]), 32'd256);

    // T6: reset during beat 2 of a 5-beat port1 packet
    do_reset();
    cfg = 8'd0;
    load_pkt(1, 5);
    for (int i = 0; i < 50 && hs_count < 1; i++) step();
    sresetn = 1'b0;
    step();
    sresetn = 1'b1;
    clear_logs();
    load_pkt(0, 2); load_pkt(2, 2);
    step();
    chk("t6_grant",  32'(obs_grant),  32'd0);
    chk("t6_busy",   32'(obs_busy),   32'd0);
    chk("t6_ovalid", 32'(obs_ovalid), 32'd0);
    drain("t6_drain", 200);
    chk("t6_order", 32'(order_code), 32'd13);

    // Random traffic: bubbles, stalls, changing gap, all three ports
    do_reset();
    vpct = 70; rdy_mode = 2; cfg_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 5)
        load_pkt(int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 6)));
      step();
    end
    drain("rand_drain", 8000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
